// File: rtl/mux_nx1_seq.sv
// -----------------------------------------------------------------------------
// mux_nx1_seq
//   Parametrised N-to-1 registered multiplexer with a valid/ready handshake.
//   One DATA_WIDTH word is picked from the packed i_data_bus by i_cmd and
//   registered. A 2-entry skid buffer (main + skid registers) lets the block
//   sustain one beat per cycle under backpressure. o_ready is driven only by
//   register state and the rst pin, so there is no combinational path from
//   i_ready to o_ready.
//
// Parameters
//   DATA_WIDTH    width of one data word
//   NUM_INPUT     number of words on i_data_bus (>= 2)
//   COMMAND_WIDTH width of i_cmd, >= clog2(NUM_INPUT)
//
// Ports
//   clk         clock, all logic on the rising edge
//   rst         synchronous reset, active-low
//   i_valid     upstream beat valid
//   i_data_bus  packed inputs, word k = i_data_bus[k*DATA_WIDTH +: DATA_WIDTH]
//   i_en        mux enable, a beat is accepted only while high
//   i_cmd       select index for the current beat
//   o_ready     block can accept a beat this cycle
//   o_valid     output word valid
//   o_data_bus  selected word (zero while o_valid is low)
//   i_ready     downstream accepts o_data_bus this cycle
//   o_cmd_err   sticky out-of-range command flag (only with
//               MUX_NX1_SEQ_CMD_ERR_EN defined)
//
// Optional feature macro: MUX_NX1_SEQ_CMD_ERR_EN
// -----------------------------------------------------------------------------
module mux_nx1_seq #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_INPUT     = 4,
  parameter int COMMAND_WIDTH = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_valid,
  input  logic [NUM_INPUT*DATA_WIDTH-1:0] i_data_bus,
  input  logic                            i_en,
  input  logic [COMMAND_WIDTH-1:0]        i_cmd,
  output logic                            o_ready,
  output logic                            o_valid,
  output logic [DATA_WIDTH-1:0]           o_data_bus,
  input  logic                            i_ready
`ifdef MUX_NX1_SEQ_CMD_ERR_EN
  ,
  output logic                            o_cmd_err
`endif
);

  // Occupancy of the two-entry buffer. main holds the head beat, skid the
  // second beat; skid is never valid without main.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   main_data_q, main_data_d;
  logic [DATA_WIDTH-1:0]   skid_data_q, skid_data_d;

  logic [DATA_WIDTH-1:0]   words [NUM_INPUT];
  logic [DATA_WIDTH-1:0]   sel_word;
  logic                    cmd_in_range;
  logic                    main_v;
  logic                    skid_v;
  logic                    accept;
  logic                    pop;

  // Unpack the input bus into an indexable word array.
  generate
    for (genvar gi = 0; gi < NUM_INPUT; gi++) begin : g_word
      assign words[gi] = i_data_bus[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Out-of-range commands fall through to the zero default.
  always_comb begin
    sel_word     = '0;
    cmd_in_range = 1'b0;
    for (int k = 0; k < NUM_INPUT; k++) begin
      if (i_cmd == COMMAND_WIDTH'(k)) begin
        sel_word     = words[k];
        cmd_in_range = 1'b1;
      end
    end
  end

  assign main_v     = (state_q != EMPTY);
  assign skid_v     = (state_q == TWO);
  assign o_ready    = rst & ~skid_v;
  assign o_valid    = main_v;
  assign o_data_bus = main_v ? main_data_q : '0;
  assign accept     = i_valid & i_en & o_ready;
  assign pop        = main_v & i_ready;

  // Next-state and data-load logic. Data registers only load on the
  // transitions that move a beat, so an idle bus never reaches them.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d     = ONE;
          main_data_d = sel_word;
        end
      end
      ONE: begin
        if (accept && pop) begin
          main_data_d = sel_word;
        end else if (accept) begin
          state_d     = TWO;
          skid_data_d = sel_word;
        end else if (pop) begin
          state_d     = EMPTY;
        end
      end
      TWO: begin
        // o_ready is low here, so only the output side can move.
        if (pop) begin
          state_d     = ONE;
          main_data_d = skid_data_q;
          skid_data_d = '0;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
    end
  end

`ifdef MUX_NX1_SEQ_CMD_ERR_EN
  logic cmd_err_q, cmd_err_d;

  // Sticky: once an out-of-range beat is accepted the flag stays set
  // until reset. With NUM_INPUT == 2**COMMAND_WIDTH every command is in
  // range, so the flag can never set.
  always_comb begin
    cmd_err_d = cmd_err_q | (accept & ~cmd_in_range);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cmd_err_q <= 1'b0;
    end else begin
      cmd_err_q <= cmd_err_d;
    end
  end

  assign o_cmd_err = cmd_err_q;
`else
  // Range information is only consumed by the error flag.
  logic unused_cmd_in_range;
  assign unused_cmd_in_range = cmd_in_range;
`endif

endmodule

// File: tb/tb_mux_nx1_seq.sv
module tb_mux_nx1_seq;

  logic         clk = 1'b0;
  logic         rst;

  // Main DUT: 4 inputs, 2-bit command.
  logic         i_valid, i_en, i_ready;
  logic [127:0] i_data_bus;
  logic [1:0]   i_cmd;
  logic         o_ready, o_valid;
  logic [31:0]  o_data_bus;

  // Second DUT: 3 inputs, 2-bit command, for out-of-range commands.
  logic         v3, en3, rdy3;
  logic [95:0]  d3;
  logic [1:0]   c3;
  logic         or3, ov3;
  logic [31:0]  od3;

`ifdef MUX_NX1_SEQ_CMD_ERR_EN
  logic         cmd_err, cmd_err3;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mux_nx1_seq #(.DATA_WIDTH(32), .NUM_INPUT(4), .COMMAND_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data_bus(i_data_bus),
    .i_en(i_en), .i_cmd(i_cmd), .o_ready(o_ready), .o_valid(o_valid),
    .o_data_bus(o_data_bus), .i_ready(i_ready)
`ifdef MUX_NX1_SEQ_CMD_ERR_EN
    , .o_cmd_err(cmd_err)
`endif
  );

  mux_nx1_seq #(.DATA_WIDTH(32), .NUM_INPUT(3), .COMMAND_WIDTH(2)) dut3 (
    .clk(clk), .rst(rst), .i_valid(v3), .i_data_bus(d3),
    .i_en(en3), .i_cmd(c3), .o_ready(or3), .o_valid(ov3),
    .o_data_bus(od3), .i_ready(rdy3)
`ifdef MUX_NX1_SEQ_CMD_ERR_EN
    , .o_cmd_err(cmd_err3)
`endif
  );

  localparam logic [31:0] W0 = 32'hAAAAAAAA;
  localparam logic [31:0] W1 = 32'h11111111;
  localparam logic [31:0] W2 = 32'h22222222;
  localparam logic [31:0] W3 = 32'h33333333;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; i_valid = 1'b0; i_en = 1'b0; i_ready = 1'b0; i_cmd = '0;
    i_data_bus = {W3, W2, W1, W0};
    v3 = 1'b0; en3 = 1'b0; rdy3 = 1'b1; c3 = '0; d3 = {W2, W1, W0};
    step(); step();
    tests_run++; if (o_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    tests_run++; if (o_data_bus !== 32'h0) begin tests_failed++; $display("FAIL reset_data: got %h want 00000000", o_data_bus); end
    tests_run++; if (o_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready_low: got %b want 0", o_ready); end
    tests_run++; if (ov3 !== 1'b0) begin tests_failed++; $display("FAIL reset_valid3: got %b want 0", ov3); end
`ifdef MUX_NX1_SEQ_CMD_ERR_EN
    tests_run++; if (cmd_err3 !== 1'b0) begin tests_failed++; $display("FAIL reset_cmd_err3: got %b want 0", cmd_err3); end
`endif
    rst = 1'b1;
    #1;
    tests_run++; if (o_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready_release: got %b want 1", o_ready); end
    $display("[TB] reset done");
  endtask

  task automatic test_select();
    i_valid = 1'b1; i_en = 1'b1; i_ready = 1'b1; i_cmd = 2'd2;
    step();
    tests_run++; if (o_valid !== 1'b1 || o_data_bus !== W2) begin tests_failed++; $display("FAIL select_cmd2: got v=%b %h want v=1 %h", o_valid, o_data_bus, W2); end
    i_cmd = 2'd0;
    step();
    tests_run++; if (o_valid !== 1'b1 || o_data_bus !== W0) begin tests_failed++; $display("FAIL select_cmd0: got v=%b %h want v=1 %h", o_valid, o_data_bus, W0); end
    i_cmd = 2'd3;
    step();
    tests_run++; if (o_valid !== 1'b1 || o_data_bus !== W3) begin tests_failed++; $display("FAIL select_cmd3: got v=%b %h want v=1 %h", o_valid, o_data_bus, W3); end
    i_valid = 1'b0;
    step();
    tests_run++; if (o_valid !== 1'b0 || o_data_bus !== 32'h0) begin tests_failed++; $display("FAIL select_drain: got v=%b %h want v=0 00000000", o_valid, o_data_bus); end
    $display("[TB] select done");
  endtask

  task automatic test_enable();
    i_en = 1'b0; i_valid = 1'b1; i_cmd = 2'd1; i_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      tests_run++; if (o_valid !== 1'b0 || o_data_bus !== 32'h0) begin tests_failed++; $display("FAIL enable_gated[%0d]: got v=%b %h want v=0 00000000", c, o_valid, o_data_bus); end
    end
    i_en = 1'b1;
    step();
    tests_run++; if (o_valid !== 1'b1 || o_data_bus !== W1) begin tests_failed++; $display("FAIL enable_beat: got v=%b %h want v=1 %h", o_valid, o_data_bus, W1); end
    i_en = 1'b0;
    step();
    tests_run++; if (o_valid !== 1'b0) begin tests_failed++; $display("FAIL enable_single: got v=%b want 0", o_valid); end
    i_valid = 1'b0;
    $display("[TB] enable done");
  endtask

  task automatic test_back_to_back();
    i_ready = 1'b0; i_valid = 1'b1; i_en = 1'b1; i_cmd = 2'd0;
    step();
    tests_run++; if (o_ready !== 1'b1 || o_data_bus !== W0) begin tests_failed++; $display("FAIL bp_first: got rdy=%b %h want rdy=1 %h", o_ready, o_data_bus, W0); end
    i_cmd = 2'd1;
    step();
    tests_run++; if (o_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_full: got rdy=%b want 0", o_ready); end
    i_cmd = 2'd2;
    for (int c = 0; c < 2; c++) begin
      step();
      tests_run++; if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_data_bus !== W0) begin tests_failed++; $display("FAIL bp_hold[%0d]: got rdy=%b v=%b %h want rdy=0 v=1 %h", c, o_ready, o_valid, o_data_bus, W0); end
    end
    // Head beat 0xAAAAAAAA is popped at this edge; beat 2 is still refused.
    i_ready = 1'b1;
    step();
    tests_run++; if (o_valid !== 1'b1 || o_data_bus !== W1 || o_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_second: got v=%b rdy=%b %h want v=1 rdy=1 %h", o_valid, o_ready, o_data_bus, W1); end
    step();
    tests_run++; if (o_valid !== 1'b1 || o_data_bus !== W2) begin tests_failed++; $display("FAIL bp_reaccept: got v=%b %h want v=1 %h", o_valid, o_data_bus, W2); end
    i_valid = 1'b0;
    step();
    tests_run++; if (o_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_no_dup: got v=%b want 0", o_valid); end
    $display("[TB] backpressure done");
  endtask

  task automatic test_mid_reset();
    i_ready = 1'b0; i_valid = 1'b1; i_en = 1'b1; i_cmd = 2'd3;
    step();
    i_cmd = 2'd2;
    step();
    tests_run++; if (o_ready !== 1'b0) begin tests_failed++; $display("FAIL mr_two: got rdy=%b want 0", o_ready); end
    rst = 1'b0; i_valid = 1'b0;
    step();
    tests_run++; if (o_valid !== 1'b0 || o_data_bus !== 32'h0 || o_ready !== 1'b0) begin tests_failed++; $display("FAIL mr_cleared: got v=%b rdy=%b %h want v=0 rdy=0 00000000", o_valid, o_ready, o_data_bus); end
    rst = 1'b1; i_ready = 1'b1;
    #1;
    tests_run++; if (o_ready !== 1'b1) begin tests_failed++; $display("FAIL mr_ready: got %b want 1", o_ready); end
    for (int c = 0; c < 2; c++) begin
      step();
      tests_run++; if (o_valid !== 1'b0 || o_data_bus !== 32'h0) begin tests_failed++; $display("FAIL mr_no_stale[%0d]: got v=%b %h want v=0 00000000", c, o_valid, o_data_bus); end
    end
    $display("[TB] mid-operation reset done");
  endtask

  task automatic test_cmd_range();
    v3 = 1'b1; en3 = 1'b1; rdy3 = 1'b1; c3 = 2'd2;
    step();
    tests_run++; if (ov3 !== 1'b1 || od3 !== W2) begin tests_failed++; $display("FAIL oor_inrange: got v=%b %h want v=1 %h", ov3, od3, W2); end
`ifdef MUX_NX1_SEQ_CMD_ERR_EN
    tests_run++; if (cmd_err3 !== 1'b0) begin tests_failed++; $display("FAIL oor_err_clear: got %b want 0", cmd_err3); end
`endif
    c3 = 2'd3;
    step();
    tests_run++; if (ov3 !== 1'b1 || od3 !== 32'h0) begin tests_failed++; $display("FAIL oor_zero: got v=%b %h want v=1 00000000", ov3, od3); end
`ifdef MUX_NX1_SEQ_CMD_ERR_EN
    tests_run++; if (cmd_err3 !== 1'b1) begin tests_failed++; $display("FAIL oor_err_set: got %b want 1", cmd_err3); end
`endif
    c3 = 2'd0;
    step();
    tests_run++; if (od3 !== W0) begin tests_failed++; $display("FAIL oor_after: got %h want %h", od3, W0); end
    v3 = 1'b0;
    step();
`ifdef MUX_NX1_SEQ_CMD_ERR_EN
    tests_run++; if (cmd_err3 !== 1'b1) begin tests_failed++; $display("FAIL oor_err_sticky: got %b want 1", cmd_err3); end
    tests_run++; if (cmd_err !== 1'b0) begin tests_failed++; $display("FAIL oor_err_full_range: got %b want 0", cmd_err); end
    rst = 1'b0;
    step();
    rst = 1'b1;
    tests_run++; if (cmd_err3 !== 1'b0) begin tests_failed++; $display("FAIL oor_err_reset: got %b want 0", cmd_err3); end
`endif
    $display("[TB] out-of-range command done");
  endtask

  // Scoreboard run: phase 0 is random valid/ready until 100 beats are
  // accepted, phase 1 holds valid/ready high, phase 2 drains.
  task automatic test_throughput();
    logic [31:0] sb[$];
    logic [31:0] exp_word;
    int acc = 0;
    int occ;
    int cyc = 0;
    int phase = 0;
    int phase_cyc = 0;
    i_en = 1'b1;
    while (phase < 3 && cyc < 5000) begin
      if (phase == 0) begin
        i_valid = 1'($urandom_range(0, 1));
        i_ready = 1'($urandom_range(0, 1));
      end else if (phase == 1) begin
        i_valid = 1'b1;
        i_ready = 1'b1;
      end else begin
        i_valid = 1'b0;
        i_ready = 1'b1;
      end
      i_cmd      = 2'($urandom_range(0, 3));
      i_data_bus = {$urandom, $urandom, $urandom, $urandom};
      #1;
      occ = sb.size();
      tests_run++; if (o_ready !== (occ < 2)) begin tests_failed++; $display("FAIL tp_ready@%0d: got %b want %b", cyc, o_ready, occ < 2); end
      tests_run++; if (o_valid !== (occ > 0)) begin tests_failed++; $display("FAIL tp_valid@%0d: got %b want %b", cyc, o_valid, occ > 0); end
      if (o_valid && i_ready && sb.size() > 0) begin
        exp_word = sb.pop_front();
        tests_run++; if (o_data_bus !== exp_word) begin tests_failed++; $display("FAIL tp_data@%0d: got %h want %h", cyc, o_data_bus, exp_word); end
      end
      if (i_valid && i_en && o_ready) begin
        sb.push_back(i_data_bus[i_cmd*32 +: 32]);
        acc++;
      end
      step();
      cyc++;
      phase_cyc++;
      if ((phase == 0 && acc >= 100) || (phase == 1 && phase_cyc >= 20) ||
          (phase == 2 && phase_cyc >= 4)) begin
        phase++;
        phase_cyc = 0;
      end
    end
    tests_run++; if (phase != 3) begin tests_failed++; $display("FAIL tp_budget: got phase %0d want 3", phase); end
    tests_run++; if (sb.size() != 0 || o_valid !== 1'b0) begin tests_failed++; $display("FAIL tp_drain: got %0d pending v=%b want 0 pending v=0", sb.size(), o_valid); end
    $display("[TB] throughput done: %0d beats accepted in %0d cycles", acc, cyc);
  endtask

  initial begin
    test_reset();
    test_select();
    test_enable();
    test_back_to_back();
    test_mid_reset();
    test_cmd_range();
    test_throughput();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
